// File: rtl/reg_file_if.sv
// Register file port bundle: write port, two read ports and busy scoreboard
// signals between decode/writeback (master) and the register file (slave).
interface reg_file_if #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 8,
   parameter int ADDR  = 3
);
   logic             WE;
   logic [ADDR-1:0]  WADDR;
   logic [SIZE-1:0]  WDATA;
   logic [ADDR-1:0]  RADDR_A;
   logic [ADDR-1:0]  RADDR_B;
   logic [SIZE-1:0]  RDATA_A;
   logic [SIZE-1:0]  RDATA_B;
   logic             BUSY_SET;
   logic [ADDR-1:0]  BUSY_ADDR;
   logic             BUSY_A;
   logic             BUSY_B;
   logic [DEPTH-1:0] BUSY_VEC;

   modport master (
      output WE, WADDR, WDATA, RADDR_A, RADDR_B, BUSY_SET, BUSY_ADDR,
      input  RDATA_A, RDATA_B, BUSY_A, BUSY_B, BUSY_VEC
   );

   modport slave (
      input  WE, WADDR, WDATA, RADDR_A, RADDR_B, BUSY_SET, BUSY_ADDR,
      output RDATA_A, RDATA_B, BUSY_A, BUSY_B, BUSY_VEC
   );
endinterface

// File: rtl/reg_file.sv
// Multi-port register file: one write port, two combinational read ports with
// write-through bypass, optional hardwired zero register, and a per-register
// busy scoreboard marking registers with a pending write.
module reg_file #(
   parameter int SIZE     = 8,
   parameter int DEPTH    = 8,
   parameter int ADDR     = 3,
   parameter int ZERO_REG = 1
) (
   input logic        CLK,
   input logic        RST,
   reg_file_if.slave  bus
);

   localparam bit HAS_ZERO = (ZERO_REG != 0);

   logic [SIZE-1:0]  regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             write_ok;
   logic             set_hits_waddr;

   // Register 0 swallows writes when it is hardwired to zero.
   assign write_ok       = bus.WE && !(HAS_ZERO && (bus.WADDR == '0));
   assign set_hits_waddr = bus.BUSY_SET && (bus.BUSY_ADDR == bus.WADDR);

   // Next busy vector: retiring write clears, issuing claim sets; set applied
   // last so a new producer supersedes the retiring one on the same register.
   always_comb begin
      busy_nxt = busy;
      if (bus.WE)
         busy_nxt[bus.WADDR] = 1'b0;
      if (bus.BUSY_SET)
         busy_nxt[bus.BUSY_ADDR] = 1'b1;
      if (HAS_ZERO)
         busy_nxt[0] = 1'b0;
   end

   // Storage and scoreboard update; reset overrides any write or claim.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         if (write_ok)
            regs[bus.WADDR] <= bus.WDATA;
         busy <= busy_nxt;
      end
   end

   // Read port A: zero register, then same-cycle write bypass, then storage.
   always_comb begin
      bus.RDATA_A = regs[bus.RADDR_A];
      bus.BUSY_A  = busy[bus.RADDR_A];
      if (HAS_ZERO && (bus.RADDR_A == '0)) begin
         bus.RDATA_A = '0;
         bus.BUSY_A  = 1'b0;
      end else if (bus.WE && (bus.WADDR == bus.RADDR_A)) begin
         bus.RDATA_A = bus.WDATA;
         // Data is already bypassed, so the reader need not wait unless a new
         // producer claims the register in the same cycle.
         if (!set_hits_waddr)
            bus.BUSY_A = 1'b0;
      end
   end

   // Read port B: same selection as port A.
   always_comb begin
      bus.RDATA_B = regs[bus.RADDR_B];
      bus.BUSY_B  = busy[bus.RADDR_B];
      if (HAS_ZERO && (bus.RADDR_B == '0)) begin
         bus.RDATA_B = '0;
         bus.BUSY_B  = 1'b0;
      end else if (bus.WE && (bus.WADDR == bus.RADDR_B)) begin
         bus.RDATA_B = bus.WDATA;
         if (!set_hits_waddr)
            bus.BUSY_B = 1'b0;
      end
   end

   assign bus.BUSY_VEC = busy;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expectations are queued as each step's stimulus
// is driven, then popped and compared once the outputs have settled.
module tb_reg_file;

   localparam int SIZE  = 8;
   localparam int DEPTH = 8;
   localparam int ADDR  = 3;

   localparam int O_RDA  = 0;
   localparam int O_RDB  = 1;
   localparam int O_BSA  = 2;
   localparam int O_BSB  = 3;
   localparam int O_BVEC = 4;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   reg_file_if #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR(ADDR)) bus ();

   reg_file #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR(ADDR), .ZERO_REG(1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         O_RDA:   return {24'd0, bus.RDATA_A};
         O_RDB:   return {24'd0, bus.RDATA_B};
         O_BSA:   return {31'd0, bus.BUSY_A};
         O_BSB:   return {31'd0, bus.BUSY_B};
         default: return {24'd0, bus.BUSY_VEC};
      endcase
   endfunction

   task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   // Let combinational outputs settle, then drain the scoreboard.
   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_vec++;
         assert (obs === e.exp)
         else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Advance through one rising edge, returning at the following falling edge.
   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle();
      bus.WE = 1'b0;  bus.WADDR = '0;  bus.WDATA = '0;
      bus.BUSY_SET = 1'b0;  bus.BUSY_ADDR = '0;
   endtask

   initial begin
      RST = 1'b1;
      idle();
      bus.RADDR_A = '0;  bus.RADDR_B = '0;
      @(negedge CLK);
      cyc();
      RST = 1'b0;
      bus.RADDR_A = 3'd7;  bus.RADDR_B = 3'd1;
      expect_val("por_rda", O_RDA, 32'h00);
      expect_val("por_rdb", O_RDB, 32'h00);
      expect_val("por_busyvec", O_BVEC, 32'h00);
      expect_val("por_busya", O_BSA, 32'h0);
      check_all();

      // Preload registers 1..7 and claim 3 and 6, then reset.
      for (int i = 1; i < DEPTH; i++) begin
         bus.WE = 1'b1;  bus.WADDR = ADDR'(i);  bus.WDATA = SIZE'(i * 17);
         cyc();
      end
      idle();
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd3;  cyc();
      bus.BUSY_ADDR = 3'd6;  cyc();
      idle();
      expect_val("pre_rda7", O_RDA, 32'h77);
      expect_val("pre_rdb1", O_RDB, 32'h11);
      expect_val("pre_busyvec", O_BVEC, 32'h48);
      check_all();
      RST = 1'b1;  cyc();  RST = 1'b0;
      expect_val("rst_rda7", O_RDA, 32'h00);
      expect_val("rst_rdb1", O_RDB, 32'h00);
      expect_val("rst_busyvec", O_BVEC, 32'h00);
      check_all();

      // Write with same-cycle bypass, then read from storage on both ports.
      bus.WE = 1'b1;  bus.WADDR = 3'd3;  bus.WDATA = 8'hA5;
      bus.RADDR_A = 3'd3;  bus.RADDR_B = 3'd4;
      expect_val("byp_rda", O_RDA, 32'hA5);
      expect_val("byp_rdb_other", O_RDB, 32'h00);
      check_all();
      cyc();  idle();  bus.RADDR_B = 3'd3;
      expect_val("wr_rda", O_RDA, 32'hA5);
      expect_val("wr_rdb", O_RDB, 32'hA5);
      check_all();

      // Both ports bypassing the same register.
      bus.WE = 1'b1;  bus.WADDR = 3'd4;  bus.WDATA = 8'h5A;
      bus.RADDR_A = 3'd4;  bus.RADDR_B = 3'd4;
      expect_val("dual_byp_rda", O_RDA, 32'h5A);
      expect_val("dual_byp_rdb", O_RDB, 32'h5A);
      check_all();
      cyc();  idle();

      // Hardwired zero register.
      bus.WE = 1'b1;  bus.WADDR = 3'd0;  bus.WDATA = 8'hFF;
      bus.RADDR_A = 3'd0;  bus.RADDR_B = 3'd0;
      expect_val("zero_byp_rda", O_RDA, 32'h00);
      expect_val("zero_byp_rdb", O_RDB, 32'h00);
      check_all();
      cyc();  idle();
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd0;
      expect_val("zero_after_rda", O_RDA, 32'h00);
      check_all();
      cyc();  idle();
      expect_val("zero_busyvec", O_BVEC, 32'h00);
      expect_val("zero_busya", O_BSA, 32'h0);
      check_all();

      // Scoreboard claim, latency, and clear on writeback.
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd5;
      bus.RADDR_A = 3'd5;  bus.RADDR_B = 3'd5;
      expect_val("claim_lat_busyvec", O_BVEC, 32'h00);
      expect_val("claim_lat_busya", O_BSA, 32'h0);
      check_all();
      cyc();  idle();
      expect_val("claim_busyvec", O_BVEC, 32'h20);
      expect_val("claim_busya", O_BSA, 32'h1);
      expect_val("claim_busyb", O_BSB, 32'h1);
      check_all();
      bus.WE = 1'b1;  bus.WADDR = 3'd5;  bus.WDATA = 8'h3C;
      expect_val("retire_busya", O_BSA, 32'h0);
      expect_val("retire_busyb", O_BSB, 32'h0);
      expect_val("retire_rda", O_RDA, 32'h3C);
      expect_val("retire_busyvec_held", O_BVEC, 32'h20);
      check_all();
      cyc();  idle();
      expect_val("retired_busyvec", O_BVEC, 32'h00);
      expect_val("retired_rda", O_RDA, 32'h3C);
      check_all();

      // Retire and re-claim the same register: claim wins, data still lands.
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd2;  cyc();  idle();
      bus.WE = 1'b1;  bus.WADDR = 3'd2;  bus.WDATA = 8'h11;
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd2;
      bus.RADDR_A = 3'd2;  bus.RADDR_B = 3'd2;
      expect_val("coll_busya", O_BSA, 32'h1);
      expect_val("coll_rda", O_RDA, 32'h11);
      check_all();
      cyc();  idle();
      expect_val("coll_rdb", O_RDB, 32'h11);
      expect_val("coll_busyvec", O_BVEC, 32'h04);
      check_all();

      // Retire and claim different registers in the same cycle.
      bus.WE = 1'b1;  bus.WADDR = 3'd2;  bus.WDATA = 8'h22;
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd7;
      bus.RADDR_A = 3'd2;  bus.RADDR_B = 3'd7;
      expect_val("diff_busya", O_BSA, 32'h0);
      expect_val("diff_busyb_nobyp", O_BSB, 32'h0);
      check_all();
      cyc();  idle();
      expect_val("diff_busyvec", O_BVEC, 32'h80);
      expect_val("diff_busyb", O_BSB, 32'h1);
      expect_val("diff_rda", O_RDA, 32'h22);
      check_all();

      // Reset arriving together with a write and a claim.
      bus.WE = 1'b1;  bus.WADDR = 3'd6;  bus.WDATA = 8'h66;  cyc();
      bus.WE = 1'b1;  bus.WADDR = 3'd6;  bus.WDATA = 8'h77;
      bus.BUSY_SET = 1'b1;  bus.BUSY_ADDR = 3'd4;  RST = 1'b1;
      cyc();
      RST = 1'b0;  idle();
      bus.RADDR_A = 3'd6;  bus.RADDR_B = 3'd2;
      expect_val("midrst_rda6", O_RDA, 32'h00);
      expect_val("midrst_rdb2", O_RDB, 32'h00);
      expect_val("midrst_busyvec", O_BVEC, 32'h00);
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port register file for the RISC-Y datapath, successor to the single enabled register. Holds DEPTH words of SIZE bits with one write port and two read ports, write-through bypass, an optional hardwired zero register, and a per-register busy scoreboard that decode uses to detect pending writes. Sits between decode (read/issue) and writeback (write).

## Interface
Parameters:
- SIZE, 8, data width of each register
- DEPTH, 8, number of registers (power of two, ≥2)
- ADDR, 3, address width; must equal log2(DEPTH)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy

Ports (one clock CLK; reset RST is synchronous and active-high):
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous active-high reset
- WE  input  1  write enable
- WADDR  input  ADDR  write address
- WDATA  input  SIZE  write data
- RADDR_A  input  ADDR  read port A address
- RADDR_B  input  ADDR  read port B address
- RDATA_A  output  SIZE  read port A data
- RDATA_B  output  SIZE  read port B data
- BUSY_SET  input  1  mark BUSY_ADDR as having a pending write
- BUSY_ADDR  input  ADDR  register being claimed by an issuing instruction
- BUSY_A  output  1  busy status of RADDR_A
- BUSY_B  output  1  busy status of RADDR_B
- BUSY_VEC  output  DEPTH  busy bit of every register, bit i = register i

## Operation
- Storage: array REGS[DEPTH] of SIZE bits; busy array BUSY[DEPTH].
- Write: rising edge with WE=1 -> REGS[WADDR] <= WDATA; BUSY[WADDR] <= 0. WE=0 -> all REGS hold.
- Read (combinational): RDATA_x = WDATA if WE=1 and WADDR==RADDR_x (bypass), else REGS[RADDR_x].
- ZERO_REG=1: writes to address 0 discarded; RDATA_x = 0 whenever RADDR_x = 0 (no bypass for address 0); BUSY_SET to address 0 ignored; BUSY[0] constant 0.
- Busy set: rising edge with BUSY_SET=1 -> BUSY[BUSY_ADDR] <= 1.
- Simultaneous WE and BUSY_SET, same address: set wins, BUSY ends at 1 (new producer supersedes retiring one); data still written.
- Simultaneous WE and BUSY_SET, different addresses: both take effect.
- BUSY_x = BUSY[RADDR_x], combinational, reflects registered state only (no bypass of same-cycle set/clear), except that a same-cycle WE to RADDR_x without a same-address BUSY_SET forces BUSY_x=0 (data already bypassed).
- Both read ports may address the same register; both return identical data.

## Timing
- Reset: rising edge with RST=1 -> all REGS = 0, all BUSY = 0; WE and BUSY_SET ignored that cycle. After reset RDATA_A/B = 0 (absent bypass), BUSY_A/B = 0, BUSY_VEC = 0.
- Reset asserted mid-operation overrides any write or set in that cycle.
- Write latency: data visible on RDATA same cycle via bypass, from REGS the cycle after the edge.
- Busy latency: BUSY_SET in cycle n -> BUSY visible from cycle n+1.
- No X on any output after first reset edge for any legal address.

## Test plan
- Reset: preload REGS via writes, assert RST one edge -> all RDATA = 0x00, BUSY_VEC = 0x00 next cycle.
- Write/read: WE=1 WADDR=3 WDATA=0xA5, RADDR_A=3 same cycle -> RDATA_A=0xA5 (bypass); next cycle WE=0 -> RDATA_A=0xA5; RADDR_B=3 -> RDATA_B=0xA5.
- Zero register (ZERO_REG=1): WE=1 WADDR=0 WDATA=0xFF, RADDR_A=0 -> RDATA_A=0x00 that cycle and after; BUSY_SET to 0 -> BUSY_VEC[0]=0.
- Scoreboard: BUSY_SET addr 5 -> next cycle BUSY_VEC=0x20, RADDR_A=5 gives BUSY_A=1; WE addr 5 WDATA=0x3C -> BUSY_A=0 same cycle, RDATA_A=0x3C, BUSY_VEC=0x00 next cycle.
- Set/clear collision: BUSY[2]=1, same cycle WE addr 2 WDATA=0x11 and BUSY_SET addr 2 -> REGS[2]=0x11, BUSY[2] stays 1.
- Reset mid-op: WE=1 WADDR=6 WDATA=0x77, BUSY_SET addr 4, RST=1 same edge -> REGS[6]=0x00, BUSY_VEC=0x00.
